// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [3:0]  HLT_OPCODE = 4'hF;
  localparam logic [15:0] PC_INC     = 16'h0002;

  function automatic logic is_hlt(input logic [15:0] instr);
    return (instr[15:12] == HLT_OPCODE);
  endfunction

endpackage

// File: rtl/fetch_ctrl_rca.sv
// 16-bit ripple-carry adder used as the fetch pc incrementer.
module rca_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [16:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < 16; gi++) begin : g_bit
    assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_cout = w_c[16];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues imem reads, buffers one instruction
// for decode, handles redirects (with drain of an in-flight read) and HLT.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic        halted
);

  localparam logic [15:0] RESET_PC_AL = RESET_PC & 16'hFFFE;

  fetch_state_e r_state;
  logic [15:0]  r_pc;
  logic [15:0]  r_req_addr;
  logic [15:0]  r_if_instr;
  logic [15:0]  r_if_pc;
  logic         r_pend;
  logic         r_if_valid;
  logic         r_halted;

  logic         w_req;
  logic         w_ack;
  logic         w_hs;
  logic         w_redirect;
  logic         w_unused_cout;
  logic [15:0]  w_pc_inc;
  logic [15:0]  w_redir_pc;

  rca_16bit u_pc_inc (
    .i_a    (r_pc),
    .i_b    (PC_INC),
    .i_cin  (1'b0),
    .o_sum  (w_pc_inc),
    .o_cout (w_unused_cout)
  );

  // A request is raised when the output slot is free or draining this cycle;
  // a raised request stays up (r_pend) until acknowledged.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      ST_FETCH: w_req = r_pend | ~r_if_valid | id_ready;
      ST_DRAIN: w_req = 1'b1;
      default:  w_req = 1'b0;
    endcase
  end

  assign w_ack      = w_req & imem_ack;
  assign w_hs       = r_if_valid & id_ready;
  assign w_redirect = redirect & (r_state != ST_IDLE);
  assign w_redir_pc = {redirect_addr[15:1], 1'b0};

  // Fetch state machine, pc, request bookkeeping and decode output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC_AL;
      r_req_addr <= RESET_PC_AL;
      r_pend     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_instr <= 16'h0000;
      r_if_pc    <= 16'h0000;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (w_redirect) begin
            r_pc       <= w_redir_pc;
            r_if_valid <= 1'b0;
            r_halted   <= 1'b0;
            r_pend     <= w_req & ~imem_ack;
            r_req_addr <= imem_addr;
            r_state    <= (w_req & ~imem_ack) ? ST_DRAIN : ST_FETCH;
          end else if (w_ack) begin
            r_if_valid <= 1'b1;
            r_if_instr <= imem_rdata;
            r_if_pc    <= r_pc;
            r_pend     <= 1'b0;
            if (is_hlt(imem_rdata)) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc     <= w_pc_inc;
            end
          end else begin
            if (w_hs) r_if_valid <= 1'b0;
            if (w_req) begin
              r_pend     <= 1'b1;
              r_req_addr <= r_pc;
            end
          end
        end
        // The old read is still owed an ack; its data is thrown away.
        ST_DRAIN: begin
          if (w_redirect) r_pc <= w_redir_pc;
          if (imem_ack) begin
            r_pend  <= 1'b0;
            r_state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (w_redirect) begin
            r_state    <= ST_FETCH;
            r_pc       <= w_redir_pc;
            r_halted   <= 1'b0;
            r_if_valid <= 1'b0;
          end else if (w_hs) begin
            r_if_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pend ? r_req_addr : r_pc;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;
  assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: memory model with random latency, a
// transaction-level instruction-stream model, and directed scenarios.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic        imem_req, if_valid, halted;
  logic [15:0] imem_addr, if_instr, if_pc;

  fetch_ctrl #(.RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .redirect(redirect), .redirect_addr(redirect_addr), .halted(halted)
  );

  // Second instance: wrap-around reset pc, zero-latency memory returning NOPs.
  logic        b_req, b_ack, b_valid, b_halted;
  logic [15:0] b_addr, b_instr, b_pc;
  assign b_ack = b_req;

  fetch_ctrl #(.RESET_PC(16'hFFFE)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(b_ack), .imem_rdata(16'h0000), .if_valid(b_valid),
    .if_instr(b_instr), .if_pc(b_pc), .id_ready(id_ready),
    .redirect(1'b0), .redirect_addr(16'h0000), .halted(b_halted)
  );

  int n_vec = 0;
  int n_err = 0;

  // stimulus controls
  bit          g_rst = 1'b0, g_rdy = 1'b1, g_rd = 1'b0, g_stale = 1'b0, g_spur = 1'b0;
  logic [15:0] g_rda = 16'h0000;
  int          g_lat = 0;
  logic [15:0] g_slow_addr = 16'h0001;
  int          g_slow_lat = 0;
  logic [15:0] hlt_addr = 16'h0001;

  // memory model state
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_addr = 16'h0000;

  // reference model state
  bit          md_live = 1'b0, md_halted = 1'b0;
  logic [15:0] md_next_pc = 16'h0000;
  int          n_pres = 0;
  bit          p_rst = 1'b1, p_req = 1'b0, p_ack = 1'b0, p_valid = 1'b0;
  bit          p_rdy = 1'b0, p_rd = 1'b0;
  logic [15:0] p_addr = 16'h0000, p_instr = 16'h0000, p_pc = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    w = (a * 16'd40503) ^ 16'h3C5A;
    if (a == 16'h0004)           w = 16'h1234;
    else if (a == hlt_addr)      w = 16'hF000;
    else if (a[7:0] == 8'hBE)    w = {4'hF, w[11:0]};
    else if (w[15:12] == 4'hF)   w = {4'h7, w[11:0]};
    return w;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, respond as memory, compare, advance model.
  task automatic step();
    int          lat;
    logic [15:0] ew;
    @(posedge clk);
    #1;
    rst_n = g_rst; id_ready = g_rdy; redirect = g_rd; redirect_addr = g_rda;
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    #1;
    if (!g_rst) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_ack = 1'b1; imem_rdata = mem_word(m_addr); m_busy = 1'b0;
      end
    end else if (imem_req) begin
      if (imem_addr == g_slow_addr) lat = g_slow_lat;
      else if (g_lat < 0)           lat = int'($urandom_range(0, 3));
      else                          lat = g_lat;
      m_addr = imem_addr;
      if (lat == 0) begin
        imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
      end else begin
        m_busy = 1'b1; m_cnt = lat;
      end
    end else if ((g_stale && !p_rst) || (g_spur && $urandom_range(0, 7) == 0)) begin
      imem_ack = 1'b1; imem_rdata = 16'hDE00 | 16'($urandom_range(0, 255));
    end
    #1;
    if (md_live) begin
      if (!p_rst) begin
        chk1("rst_req", imem_req, 1'b0);
        chk16("rst_addr", imem_addr, 16'h0000);
        chk1("rst_valid", if_valid, 1'b0);
        chk16("rst_instr", if_instr, 16'h0000);
        chk16("rst_pc", if_pc, 16'h0000);
        chk1("rst_halted", halted, 1'b0);
      end else begin
        if (imem_req) chk1("addr_bit0", imem_addr[0], 1'b0);
        if (p_req && !p_ack) begin
          chk1("req_hold", imem_req, 1'b1);
          chk16("addr_hold", imem_addr, p_addr);
        end
        if (p_rd) begin
          chk1("flush_valid", if_valid, 1'b0);
          chk1("flush_halted", halted, 1'b0);
        end else if (p_valid && !p_rdy) begin
          chk1("stall_valid", if_valid, 1'b1);
          chk16("stall_instr", if_instr, p_instr);
          chk16("stall_pc", if_pc, p_pc);
        end else if (if_valid) begin
          ew = mem_word(md_next_pc);
          chk16("pres_pc", if_pc, md_next_pc);
          chk16("pres_instr", if_instr, ew);
          if (ew[15:12] == 4'hF) md_halted = 1'b1;
          md_next_pc = md_next_pc + 16'h0002;
          n_pres++;
        end
        chk1("halted", halted, md_halted);
        if (md_halted) chk1("halt_noreq", imem_req, 1'b0);
      end
    end
    if (!g_rst) begin
      md_next_pc = 16'h0000; md_halted = 1'b0; md_live = 1'b1;
    end else if (g_rd) begin
      md_next_pc = g_rda & 16'hFFFE; md_halted = 1'b0;
    end
    p_rst = g_rst; p_req = imem_req; p_addr = imem_addr; p_ack = imem_ack;
    p_valid = if_valid; p_rdy = id_ready; p_rd = g_rd; p_instr = if_instr; p_pc = if_pc;
  endtask

  task automatic do_reset();
    g_rd = 1'b0; g_rst = 1'b0;
    step(); step();
    g_rst = 1'b1;
    step();
  endtask

  task automatic wait_req(input logic [15:0] a);
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (imem_req && imem_addr == a) begin ok = 1'b1; break; end
    end
    chk1("wait_req", ok, 1'b1);
  endtask

  task automatic wait_pres(input logic [15:0] a);
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (if_valid && if_pc == a) begin ok = 1'b1; break; end
    end
    chk1("wait_pres", ok, 1'b1);
  endtask

  initial begin
    int n_stall_ack;

    // Reset bubble, back-to-back fetch, stale ack after reset, pc wrap.
    g_lat = 0; g_rdy = 1'b1; g_stale = 1'b1;
    do_reset();
    chk1("idle_bubble", imem_req, 1'b0);
    chk1("wrap_idle", b_req, 1'b0);
    g_stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("seq_req", imem_req, 1'b1);
      chk16("seq_addr", imem_addr, 16'(2 * i));
      chk16("wrap_addr", b_addr, 16'hFFFE + 16'(2 * i));
      if (i >= 1) begin
        chk1("seq_valid", if_valid, 1'b1);
        chk16("seq_pc", if_pc, 16'(2 * (i - 1)));
        chk16("wrap_pc", b_pc, 16'hFFFE + 16'(2 * (i - 1)));
        chk16("wrap_instr", b_instr, 16'h0000);
        chk1("wrap_valid", b_valid, 1'b1);
      end
    end
    chk1("wrap_halted", b_halted, 1'b0);

    // Decode stall on 16'h1234 at 16'h0004.
    do_reset();
    step(); step(); step();
    g_rdy = 1'b0;
    n_stall_ack = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk1("stall_v", if_valid, 1'b1);
      chk16("stall_i", if_instr, 16'h1234);
      chk16("stall_p", if_pc, 16'h0004);
      n_stall_ack += int'(imem_req & imem_ack);
    end
    chk1("stall_req_le1", n_stall_ack <= 1, 1'b1);
    g_rdy = 1'b1;
    step(); step(); step();

    // Redirect while a slow read to 16'h0010 is outstanding.
    g_slow_addr = 16'h0010; g_slow_lat = 4;
    do_reset();
    wait_req(16'h0010);
    g_rd = 1'b1; g_rda = 16'h0041;
    step();
    g_rd = 1'b0;
    chk16("drain_addr0", imem_addr, 16'h0010);
    for (int k = 0; k < 3; k++) begin
      step();
      chk1("drain_req", imem_req, 1'b1);
      chk16("drain_addr", imem_addr, 16'h0010);
      chk1("drain_valid", if_valid, 1'b0);
    end
    step();
    chk1("redir_req", imem_req, 1'b1);
    chk16("redir_addr", imem_addr, 16'h0040);
    step();
    chk1("redir_valid", if_valid, 1'b1);
    chk16("redir_pc", if_pc, 16'h0040);
    g_slow_addr = 16'h0001;

    // HLT at 16'h0020, then resume at 16'h0100.
    hlt_addr = 16'h0020;
    do_reset();
    wait_pres(16'h0020);
    chk16("hlt_instr", if_instr, 16'hF000);
    chk1("hlt_halted", halted, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk1("hlt_noreq", imem_req, 1'b0);
    end
    g_rd = 1'b1; g_rda = 16'h0100;
    step();
    g_rd = 1'b0;
    step();
    chk1("resume_req", imem_req, 1'b1);
    chk16("resume_addr", imem_addr, 16'h0100);
    chk1("resume_halted", halted, 1'b0);
    step();
    chk16("resume_pc", if_pc, 16'h0100);
    hlt_addr = 16'h0001;

    // Reset in DRAIN with a stale ack right after reset.
    g_slow_addr = 16'h0008; g_slow_lat = 3;
    do_reset();
    wait_req(16'h0008);
    g_rd = 1'b1; g_rda = 16'h0030;
    step();
    g_rd = 1'b0;
    step();
    chk16("drain2_addr", imem_addr, 16'h0008);
    g_rst = 1'b0;
    step();
    g_rst = 1'b1; g_stale = 1'b1;
    step();
    chk1("rst_drain_req", imem_req, 1'b0);
    g_stale = 1'b0;
    step();
    chk16("restart_addr", imem_addr, 16'h0000);
    step();
    chk16("restart_pc", if_pc, 16'h0000);
    chk16("restart_instr", if_instr, mem_word(16'h0000));
    g_slow_addr = 16'h0001;

    // Randomized traffic.
    g_lat = -1; g_spur = 1'b1; n_pres = 0;
    for (int c = 0; c < 3000; c++) begin
      g_rst = ($urandom_range(0, 599) != 0);
      g_rdy = ($urandom_range(0, 3) != 0);
      g_rd  = g_rst && p_rst && ($urandom_range(0, 11) == 0);
      g_rda = 16'($urandom);
      step();
    end
    chk1("progress", n_pres > 200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
